// File: rtl/axi_rd_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_arb_pkg
// Purpose  : Shared state encoding and AXI constants for the read arbiter.
// Revision : 1.0  initial release
// ============================================================================
package axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  localparam logic [1:0] BURST_INCR = 2'd1;
  localparam logic [1:0] RESP_OKAY  = 2'd0;

endpackage
`default_nettype wire

// File: rtl/axi_rd_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick2
// Purpose  : Combinational two-way round-robin picker. When both ports
//            request, the preferred port (prio_i) wins.
// Revision : 1.0  initial release
// ============================================================================
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic       gnt_idx_o,
  output logic       gnt_any_o
);

  // Single requester wins outright; a tie goes to the preferred port
  always_comb begin
    gnt_any_o = |req_i;
    gnt_idx_o = 1'b0;
    unique case (req_i)
      2'b01:   gnt_idx_o = 1'b0;
      2'b10:   gnt_idx_o = 1'b1;
      2'b11:   gnt_idx_o = prio_i;
      default: gnt_idx_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_arbiter
// Purpose  : Shares one AXI4 read channel between two burst masters
//            (port 0 icache refill, port 1 dcache/uncached). One outstanding
//            transaction; round-robin grant held from AR handshake to rlast.
// Revision : 1.0  initial release
// ============================================================================
module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // port 0
  input  logic              m0_arvalid_i,
  input  logic [ADDR_W-1:0] m0_araddr_i,
  input  logic [ID_W-1:0]   m0_arid_i,
  input  logic [7:0]        m0_arlen_i,
  input  logic [1:0]        m0_arburst_i,
  output logic              m0_arready_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic [1:0]        m0_rresp_o,
  output logic [ID_W-1:0]   m0_rid_o,
  output logic              m0_rlast_o,
  output logic              m0_rvalid_o,
  input  logic              m0_rready_i,
  // port 1
  input  logic              m1_arvalid_i,
  input  logic [ADDR_W-1:0] m1_araddr_i,
  input  logic [ID_W-1:0]   m1_arid_i,
  input  logic [7:0]        m1_arlen_i,
  input  logic [1:0]        m1_arburst_i,
  output logic              m1_arready_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic [1:0]        m1_rresp_o,
  output logic [ID_W-1:0]   m1_rid_o,
  output logic              m1_rlast_o,
  output logic              m1_rvalid_o,
  input  logic              m1_rready_i,
  // downstream
  output logic              s_arvalid_o,
  output logic [ADDR_W-1:0] s_araddr_o,
  output logic [ID_W-1:0]   s_arid_o,
  output logic [7:0]        s_arlen_o,
  output logic [1:0]        s_arburst_o,
  input  logic              s_arready_i,
  input  logic [DATA_W-1:0] s_rdata_i,
  input  logic [1:0]        s_rresp_i,
  input  logic [ID_W-1:0]   s_rid_i,
  input  logic              s_rlast_i,
  input  logic              s_rvalid_i,
  output logic              s_rready_o
);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       prio_q,  prio_d;

  logic       pick_idx;
  logic       pick_any;
  logic       gnt_arvalid;
  logic       gnt_rready;

  rr_pick2 u_pick (
    .req_i     ({m1_arvalid_i, m0_arvalid_i}),
    .prio_i    (prio_q),
    .gnt_idx_o (pick_idx),
    .gnt_any_o (pick_any)
  );

  assign gnt_arvalid = grant_q ? m1_arvalid_i : m0_arvalid_i;
  assign gnt_rready  = grant_q ? m1_rready_i  : m0_rready_i;

  // State, grant and priority flops; reset takes effect immediately
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
    end
  end

  // Next-state: arbitrate in IDLE, wait for AR handshake, wait for last beat
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (gnt_arvalid && s_arready_i) begin
          state_d = ST_DATA;
        end else if (!gnt_arvalid) begin
          // requester withdrew without handshake: abandon, keep priority
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (s_rvalid_i && gnt_rready && s_rlast_i) begin
          state_d = ST_IDLE;
          prio_d  = ~grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output steering: AR path only in ADDR, R path only in DATA, else zeros
  always_comb begin
    s_arvalid_o  = 1'b0;
    s_araddr_o   = '0;
    s_arid_o     = '0;
    s_arlen_o    = '0;
    s_arburst_o  = '0;
    s_rready_o   = 1'b0;
    m0_arready_o = 1'b0;
    m1_arready_o = 1'b0;
    m0_rdata_o   = '0;
    m0_rresp_o   = '0;
    m0_rid_o     = '0;
    m0_rlast_o   = 1'b0;
    m0_rvalid_o  = 1'b0;
    m1_rdata_o   = '0;
    m1_rresp_o   = '0;
    m1_rid_o     = '0;
    m1_rlast_o   = 1'b0;
    m1_rvalid_o  = 1'b0;
    if (state_q == ST_ADDR) begin
      s_arvalid_o = gnt_arvalid;
      if (grant_q) begin
        s_araddr_o   = m1_araddr_i;
        s_arid_o     = m1_arid_i;
        s_arlen_o    = m1_arlen_i;
        s_arburst_o  = m1_arburst_i;
        m1_arready_o = s_arready_i;
      end else begin
        s_araddr_o   = m0_araddr_i;
        s_arid_o     = m0_arid_i;
        s_arlen_o    = m0_arlen_i;
        s_arburst_o  = m0_arburst_i;
        m0_arready_o = s_arready_i;
      end
    end else if (state_q == ST_DATA) begin
      // beats follow the grant, never the returned ID
      s_rready_o = gnt_rready;
      if (grant_q) begin
        m1_rdata_o  = s_rdata_i;
        m1_rresp_o  = s_rresp_i;
        m1_rid_o    = s_rid_i;
        m1_rlast_o  = s_rlast_i;
        m1_rvalid_o = s_rvalid_i;
      end else begin
        m0_rdata_o  = s_rdata_i;
        m0_rresp_o  = s_rresp_i;
        m0_rid_o    = s_rid_i;
        m0_rlast_o  = s_rlast_i;
        m0_rvalid_o = s_rvalid_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_rd_arbiter
// Purpose  : Directed self-checking bench for axi_rd_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi_rd_arbiter;
  import axi_rd_arb_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        m0_arvalid_i = 0, m1_arvalid_i = 0;
  logic [31:0] m0_araddr_i = 0, m1_araddr_i = 0;
  logic [3:0]  m0_arid_i = 0, m1_arid_i = 0;
  logic [7:0]  m0_arlen_i = 0, m1_arlen_i = 0;
  logic [1:0]  m0_arburst_i = 0, m1_arburst_i = 0;
  logic        m0_arready_o, m1_arready_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic [1:0]  m0_rresp_o, m1_rresp_o;
  logic [3:0]  m0_rid_o, m1_rid_o;
  logic        m0_rlast_o, m1_rlast_o, m0_rvalid_o, m1_rvalid_o;
  logic        m0_rready_i = 1, m1_rready_i = 1;
  logic        s_arvalid_o;
  logic [31:0] s_araddr_o;
  logic [3:0]  s_arid_o;
  logic [7:0]  s_arlen_o;
  logic [1:0]  s_arburst_o;
  logic        s_arready_i = 0;
  logic [31:0] s_rdata_i = 0;
  logic [1:0]  s_rresp_i = 0;
  logic [3:0]  s_rid_i = 0;
  logic        s_rlast_i = 0, s_rvalid_i = 0;
  logic        s_rready_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_arvalid_i(m0_arvalid_i), .m0_araddr_i(m0_araddr_i), .m0_arid_i(m0_arid_i),
    .m0_arlen_i(m0_arlen_i), .m0_arburst_i(m0_arburst_i), .m0_arready_o(m0_arready_o),
    .m0_rdata_o(m0_rdata_o), .m0_rresp_o(m0_rresp_o), .m0_rid_o(m0_rid_o),
    .m0_rlast_o(m0_rlast_o), .m0_rvalid_o(m0_rvalid_o), .m0_rready_i(m0_rready_i),
    .m1_arvalid_i(m1_arvalid_i), .m1_araddr_i(m1_araddr_i), .m1_arid_i(m1_arid_i),
    .m1_arlen_i(m1_arlen_i), .m1_arburst_i(m1_arburst_i), .m1_arready_o(m1_arready_o),
    .m1_rdata_o(m1_rdata_o), .m1_rresp_o(m1_rresp_o), .m1_rid_o(m1_rid_o),
    .m1_rlast_o(m1_rlast_o), .m1_rvalid_o(m1_rvalid_o), .m1_rready_i(m1_rready_i),
    .s_arvalid_o(s_arvalid_o), .s_araddr_o(s_araddr_o), .s_arid_o(s_arid_o),
    .s_arlen_o(s_arlen_o), .s_arburst_o(s_arburst_o), .s_arready_i(s_arready_i),
    .s_rdata_i(s_rdata_i), .s_rresp_i(s_rresp_i), .s_rid_i(s_rid_i),
    .s_rlast_i(s_rlast_i), .s_rvalid_i(s_rvalid_i), .s_rready_o(s_rready_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic req(input bit p, input logic [31:0] addr, input logic [3:0] id, input int nbeats);
    if (p) begin
      m1_arvalid_i = 1; m1_araddr_i = addr; m1_arid_i = id;
      m1_arlen_i = 8'(nbeats - 1); m1_arburst_i = BURST_INCR;
    end else begin
      m0_arvalid_i = 1; m0_araddr_i = addr; m0_arid_i = id;
      m0_arlen_i = 8'(nbeats - 1); m0_arburst_i = BURST_INCR;
    end
  endtask

  // Entered just after a negedge with the DUT expected in ADDR granting port p;
  // returns just after the negedge following the last beat (DUT back in IDLE).
  task automatic serve(input bit p, input logic [31:0] addr, input logic [3:0] id,
                       input int nbeats, input int stall, input bit toggle, input int err_beat);
    int acc;
    int cyc;
    logic rr;
    logic exp_prio;
    exp_prio = ~p;
    s_arready_i = 0;
    for (int k = 0; k < stall; k++) begin
      #1;
      chk("stall_arvalid", s_arvalid_o, 1);
      chk("stall_araddr", s_araddr_o, addr);
      chk("stall_arready", p ? m1_arready_o : m0_arready_o, 0);
      tick();
    end
    s_arready_i = 1;
    #1;
    chk("ar_valid", s_arvalid_o, 1);
    chk("ar_addr", s_araddr_o, addr);
    chk("ar_id", s_arid_o, id);
    chk("ar_len", s_arlen_o, nbeats - 1);
    chk("ar_burst", s_arburst_o, BURST_INCR);
    chk("arready_gnt", p ? m1_arready_o : m0_arready_o, 1);
    chk("arready_oth", p ? m0_arready_o : m1_arready_o, 0);
    tick();
    s_arready_i = 0;
    if (p) m1_arvalid_i = 0; else m0_arvalid_i = 0;
    acc = 0;
    cyc = 0;
    while (acc < nbeats && cyc < 200) begin
      rr = toggle ? (cyc % 2 == 0) : 1'b1;
      if (p) begin m1_rready_i = rr; m0_rready_i = 1; end
      else   begin m0_rready_i = rr; m1_rready_i = 1; end
      s_rvalid_i = 1;
      s_rdata_i  = addr + 32'(acc);
      s_rid_i    = id;
      s_rresp_i  = (acc == err_beat) ? 2'b10 : RESP_OKAY;
      s_rlast_i  = (acc == nbeats - 1);
      #1;
      chk("rvalid", p ? m1_rvalid_o : m0_rvalid_o, 1);
      chk("rdata", p ? m1_rdata_o : m0_rdata_o, addr + 32'(acc));
      chk("rid", p ? m1_rid_o : m0_rid_o, id);
      chk("rresp", p ? m1_rresp_o : m0_rresp_o, (acc == err_beat) ? 2'b10 : 2'b00);
      chk("rlast", p ? m1_rlast_o : m0_rlast_o, (acc == nbeats - 1) ? 1 : 0);
      chk("rready_mirror", s_rready_o, rr);
      chk("oth_rvalid", p ? m0_rvalid_o : m1_rvalid_o, 0);
      chk("oth_rdata", p ? m0_rdata_o : m1_rdata_o, 0);
      if (rr) acc++;
      cyc++;
      tick();
    end
    chk("beats_done", acc, nbeats);
    s_rvalid_i = 0; s_rlast_i = 0; s_rdata_i = 0; s_rresp_i = 0; s_rid_i = 0;
    m0_rready_i = 1; m1_rready_i = 1;
    #1;
    chk("end_state_idle", dut.state_q, ST_IDLE);
    chk("end_prio", dut.prio_q, exp_prio);
    chk("end_arvalid", s_arvalid_o, 0);
  endtask

  initial begin
    // ---- reset values
    rst_i = 1;
    s_rvalid_i = 1;
    s_rlast_i = 1;
    s_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk("rst_s_arvalid", s_arvalid_o, 0);
    chk("rst_s_araddr", s_araddr_o, 0);
    chk("rst_s_rready", s_rready_o, 0);
    chk("rst_m0_rvalid", m0_rvalid_o, 0);
    chk("rst_m1_rlast", m1_rlast_o, 0);
    chk("rst_m0_rdata", m0_rdata_o, 0);
    chk("rst_state", dut.state_q, ST_IDLE);
    chk("rst_prio", dut.prio_q, 0);
    tick(); tick();
    rst_i = 0;
    tick();
    // stray beat in IDLE is not accepted
    #1;
    chk("idle_stray_rready", s_rready_o, 0);
    chk("idle_stray_m0_rvalid", m0_rvalid_o, 0);
    chk("idle_stray_m1_rvalid", m1_rvalid_o, 0);
    s_rvalid_i = 0; s_rlast_i = 0; s_rdata_i = 0;
    tick();

    // ---- single port 0 request, 8 beats; one-cycle arbitration latency
    req(0, 32'h0000_1000, 4'h3, 8);
    #1;
    chk("lat_cycle0_arvalid", s_arvalid_o, 0);
    tick();
    serve(0, 32'h0000_1000, 4'h3, 8, 0, 0, -1);
    tick();

    // ---- simultaneous requests from reset: port 0 then port 1
    rst_i = 1; tick(); rst_i = 0; tick();
    req(0, 32'h100, 4'h1, 2);
    req(1, 32'h200, 4'h2, 2);
    tick();
    serve(0, 32'h100, 4'h1, 2, 0, 0, -1);
    chk("sim_m1_still_req", m1_arvalid_i, 1);
    tick();
    serve(1, 32'h200, 4'h2, 2, 0, 0, -1);

    // ---- continuous requests, four bursts alternate 0,1,0,1
    req(0, 32'h3000, 4'h4, 3);
    req(1, 32'h4000, 4'h5, 3);
    tick();
    serve(0, 32'h3000, 4'h4, 3, 0, 0, -1);
    req(0, 32'h3100, 4'h4, 3);
    tick();
    serve(1, 32'h4000, 4'h5, 3, 0, 0, -1);
    req(1, 32'h4100, 4'h5, 3);
    tick();
    serve(0, 32'h3100, 4'h4, 3, 0, 0, -1);
    tick();
    serve(1, 32'h4100, 4'h5, 3, 0, 0, -1);
    tick();

    // ---- AR backpressure 5 cycles, m1 rready toggling
    req(1, 32'h5000, 4'h6, 4);
    tick();
    serve(1, 32'h5000, 4'h6, 4, 5, 1, -1);
    tick();

    // ---- SLVERR on beat 3 of port 1
    req(1, 32'h6000, 4'h7, 4);
    tick();
    serve(1, 32'h6000, 4'h7, 4, 0, 0, 2);
    tick();

    // ---- requester withdraws in ADDR: back to IDLE, priority kept
    req(0, 32'h7000, 4'h8, 1);
    tick();
    m0_arvalid_i = 0;
    #1;
    chk("withdraw_arvalid", s_arvalid_o, 0);
    tick();
    #1;
    chk("withdraw_state", dut.state_q, ST_IDLE);
    chk("withdraw_prio", dut.prio_q, 0);
    tick();

    // ---- reset asserted on beat 4 of 8
    req(1, 32'h8000, 4'h9, 8);
    tick();
    s_arready_i = 1;
    tick();
    s_arready_i = 0;
    m1_arvalid_i = 0;
    for (int b = 0; b < 3; b++) begin
      s_rvalid_i = 1; s_rdata_i = 32'h8000 + 32'(b); s_rid_i = 4'h9;
      #1;
      chk("pre_rst_beat", m1_rdata_o, 32'h8000 + 32'(b));
      tick();
    end
    s_rvalid_i = 1; s_rdata_i = 32'h8003;
    rst_i = 1;
    #1;
    chk("midrst_m1_rvalid", m1_rvalid_o, 0);
    chk("midrst_m1_rdata", m1_rdata_o, 0);
    chk("midrst_m1_rid", m1_rid_o, 0);
    chk("midrst_s_rready", s_rready_o, 0);
    chk("midrst_s_arvalid", s_arvalid_o, 0);
    chk("midrst_state", dut.state_q, ST_IDLE);
    chk("midrst_prio", dut.prio_q, 0);
    tick();
    rst_i = 0;
    s_rvalid_i = 0; s_rdata_i = 0; s_rid_i = 0;
    req(1, 32'h9000, 4'hA, 2);
    tick();
    serve(1, 32'h9000, 4'hA, 2, 0, 0, -1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
